// File: rtl/mem_byte_streamer_pkg.sv
// Shared constants for the memory byte streamer: default parameters, top-level FSM
// encoding and strobe-phase encoding.
package mem_byte_streamer_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_LEN_W       = 11;
  localparam int unsigned DEF_HALF_PERIOD = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

  typedef logic [1:0] phase_t;
  localparam phase_t PH_IDLE = 2'd0;
  localparam phase_t PH_HIGH = 2'd1;
  localparam phase_t PH_LOW  = 2'd2;

  // Width of the byte-lane index; kept at least 1 so an 8-bit memory still has a legal vector.
  function automatic int unsigned lane_bits(input int unsigned data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through read data and an occupancy count.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [7:0]     mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == (PTR_W + 1)'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_byte_streamer.sv
// Streams bytes from a word-wide memory to a parallel port, one byte per read, through a
// byte FIFO; output is a timed strobe or an ack handshake, with optional stop at NUL.
module mem_byte_streamer
  import mem_byte_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned LEN_W       = DEF_LEN_W,
  parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  max_len,
  input  logic              nul_stop,
  input  logic              ack_mode,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        out_data,
  output logic              out_strobe,
  input  logic              out_ack,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  sent_count
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned LANE_W = lane_bits(DATA_W);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W  = $clog2(HALF_PERIOD + 1);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BYTES - 1);

  // Transfer control
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  max_len_q;
  logic              nul_stop_q;
  logic              ack_mode_q;
  logic [LEN_W-1:0]  fetched_q;
  logic              inflight_q;
  logic [LANE_W-1:0] lane_q;
  logic              nul_seen_q;

  // Output side
  phase_t            phase_q, phase_d;
  logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_strobe_q, out_strobe_d;
  logic [LEN_W-1:0]  sent_count_q, sent_count_d;

  logic              accept;
  logic              fetch_more;
  logic              issue;
  logic [LVL_W:0]    occupancy;
  logic [7:0]        rd_byte;
  logic              rd_is_nul;
  logic              push;
  logic              pop;
  logic              load_next;
  logic              cnt_last;
  logic              done_w;

  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (rd_byte),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign accept     = (state_q == ST_IDLE) && start;
  assign fetch_more = (state_q == ST_RUN) && !nul_seen_q && (fetched_q < max_len_q);
  // Count the outstanding read against the FIFO so its byte always has a slot.
  assign occupancy  = {1'b0, fifo_level} + {{LVL_W{1'b0}}, inflight_q};
  assign issue      = fetch_more && (occupancy < (LVL_W + 1)'(FIFO_DEPTH));
  assign rd_byte    = 8'(mem_rdata >> {lane_q, 3'b000});
  assign rd_is_nul  = nul_stop_q && (rd_byte == 8'h00);
  // A read returning after the NUL was seen is dropped, as is the NUL itself.
  assign push       = inflight_q && !nul_seen_q && !rd_is_nul && !fifo_full;
  assign cnt_last   = (phase_cnt_q == CNT_W'(HALF_PERIOD - 1));

  assign mem_rd_en  = issue;
  assign mem_addr   = addr_q & ~LANE_MASK;
  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign sent_count = sent_count_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_w;

  always_comb begin
    state_d = state_q;
    done_w  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!inflight_q && (nul_seen_q || (fetched_q == max_len_q))) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (fifo_empty && (phase_q == PH_IDLE)) begin
          state_d = ST_IDLE;
          done_w  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_d      = phase_q;
    phase_cnt_d  = phase_cnt_q;
    out_data_d   = out_data_q;
    out_strobe_d = out_strobe_q;
    sent_count_d = sent_count_q;
    load_next    = 1'b0;
    pop          = 1'b0;
    unique case (phase_q)
      PH_IDLE: begin
        load_next = !fifo_empty;
      end
      PH_HIGH: begin
        if (ack_mode_q ? out_ack : cnt_last) begin
          out_strobe_d = 1'b0;
          phase_d      = PH_LOW;
          phase_cnt_d  = '0;
          if (sent_count_q < max_len_q) sent_count_d = sent_count_q + 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      PH_LOW: begin
        if (ack_mode_q ? !out_ack : cnt_last) begin
          if (fifo_empty) phase_d = PH_IDLE;
          else            load_next = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
    // Chain straight from the low phase into the next byte so the period stays exact.
    if (load_next) begin
      pop          = 1'b1;
      out_data_d   = fifo_rdata;
      out_strobe_d = 1'b1;
      phase_d      = PH_HIGH;
      phase_cnt_d  = '0;
    end
    if (accept) sent_count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      max_len_q    <= '0;
      nul_stop_q   <= 1'b0;
      ack_mode_q   <= 1'b0;
      fetched_q    <= '0;
      inflight_q   <= 1'b0;
      lane_q       <= '0;
      nul_seen_q   <= 1'b0;
      phase_q      <= PH_IDLE;
      phase_cnt_q  <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= issue;
      phase_q      <= phase_d;
      phase_cnt_q  <= phase_cnt_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      sent_count_q <= sent_count_d;
      if (accept) begin
        addr_q     <= base_addr;
        max_len_q  <= max_len;
        nul_stop_q <= nul_stop;
        ack_mode_q <= ack_mode;
        fetched_q  <= '0;
        nul_seen_q <= 1'b0;
      end else begin
        if (issue) begin
          addr_q    <= addr_q + 1'b1;
          fetched_q <= fetched_q + 1'b1;
          lane_q    <= addr_q[LANE_W-1:0] & LANE_MASK[LANE_W-1:0];
        end
        if (inflight_q && rd_is_nul) nul_seen_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_byte_streamer.sv
// Randomised scoreboard bench for mem_byte_streamer: a byte-array memory model predicts each
// transfer's byte sequence, and a negedge monitor checks strobes, done and sent_count.
module tb_mem_byte_streamer;

  localparam int unsigned HALF  = 4;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [10:0] max_len;
  logic        nul_stop;
  logic        ack_mode;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  out_data;
  logic        out_strobe;
  logic        out_ack;
  logic        busy;
  logic        done;
  logic [10:0] sent_count;

  mem_byte_streamer #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .FIFO_DEPTH  (DEPTH),
    .LEN_W       (11),
    .HALF_PERIOD (HALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .max_len    (max_len),
    .nul_stop   (nul_stop),
    .ack_mode   (ack_mode),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .out_ack    (out_ack),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [7:0]  mem_b [4096];
  logic [7:0]  exp_q [$];
  int          exp_sent;
  bit          cur_ack;
  bit          ack_en     = 1'b0;
  int          ack_delay  = 0;
  int          drop_delay = 0;
  int          done_cnt   = 0;
  int          done_cyc   = 0;
  int          tr_strobes = 0;
  int          max_level  = 0;
  bit          prev_strobe;
  logic [7:0]  prev_data;
  int          high_len;
  bit          data_moved;
  logic [7:0]  exp_b;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] ai;
    for (int i = 0; i < 4; i++) begin
      ai = a + 32'(i);
      w[8*i +: 8] = mem_b[ai[11:0]];
    end
    return w;
  endfunction

  always @(posedge clk) cyc++;

  // Memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= word_at(mem_addr);
  end

  // Acknowledge responder for ack mode.
  initial begin
    out_ack = 1'b0;
    forever begin
      tick();
      if (rst || !ack_en) begin
        out_ack = 1'b0;
      end else if (out_strobe && !out_ack) begin
        repeat (ack_delay) tick();
        out_ack = 1'b1;
      end else if (!out_strobe && out_ack) begin
        repeat (drop_delay) tick();
        out_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the expected byte on every strobe falling edge and checks each done pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
      high_len    = 0;
      data_moved  = 1'b0;
    end else begin
      if (mem_rd_en) check(mem_addr[1:0] == 2'b00, "mem_addr_align", mem_addr, 0);
      if (int'(dut.u_fifo.level) > max_level) max_level = int'(dut.u_fifo.level);
      if (out_strobe) begin
        if (prev_strobe && out_data != prev_data) data_moved = 1'b1;
        high_len++;
      end
      if (prev_strobe && !out_strobe) begin
        tr_strobes++;
        if (exp_q.size() == 0) begin
          check(1'b0, "extra_byte", out_data, 0);
        end else begin
          exp_b = exp_q.pop_front();
          check(out_data == exp_b, "byte_value", out_data, exp_b);
        end
        if (!cur_ack) check(high_len == int'(HALF), "strobe_high_len", high_len, HALF);
        check(!data_moved, "data_stable", data_moved, 0);
        high_len   = 0;
        data_moved = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check(sent_count == 11'(exp_sent), "sent_count", sent_count, exp_sent);
        check(exp_q.size() == 0, "bytes_missing", exp_q.size(), 0);
      end
      prev_strobe = out_strobe;
      prev_data   = out_data;
    end
  end

  task automatic load_expect(input logic [31:0] base, input int len, input bit nul, input bit ack);
    logic [31:0] a;
    logic [7:0]  b;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      a = base + 32'(i);
      b = mem_b[a[11:0]];
      if (nul && b == 8'h00) break;
      exp_q.push_back(b);
    end
    exp_sent   = exp_q.size();
    cur_ack    = ack;
    ack_en     = ack;
    tr_strobes = 0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input int len, input bit nul, input bit ack);
    base_addr = base;
    max_len   = 11'(len);
    nul_stop  = nul;
    ack_mode  = ack;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic do_transfer(input logic [31:0] base, input int len, input bit nul,
                             input bit ack, input bit poke_busy);
    int d0;
    int s_cyc;
    int n;
    int n_exp;
    load_expect(base, len, nul, ack);
    n_exp = exp_sent;
    d0    = done_cnt;
    s_cyc = cyc;
    pulse_start(base, len, nul, ack);
    if (poke_busy) begin
      repeat (3) tick();
      check(busy == 1'b1, "busy_mid", busy, 1);
      pulse_start(32'h0000_0100, 5, 1'b0, 1'b0);
    end
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      tick();
      n++;
    end
    check(done_cnt == d0 + 1, "done_seen", done_cnt - d0, 1);
    if (len == 0) check(done_cyc - s_cyc == 2, "zero_len_latency", done_cyc - s_cyc, 2);
    check(tr_strobes == n_exp, "strobe_count", tr_strobes, n_exp);
    repeat (3) tick();
    check(busy == 1'b0, "idle_after_done", busy, 0);
    check(done_cnt == d0 + 1, "single_done", done_cnt - d0, 1);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 4096; i++)
      mem_b[i] = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    mem_b[12'h100] = 8'h48;
    mem_b[12'h101] = 8'h45;
    mem_b[12'h102] = 8'h4C;
    mem_b[12'h103] = 8'h4C;
    mem_b[12'h104] = 8'h4F;
    mem_b[12'h105] = 8'h00;
    mem_b[12'h106] = 8'h58;
    mem_b[12'h107] = 8'h59;
    for (int i = 0; i < 40; i++) mem_b[12'h200 + 12'(i)] = 8'($urandom_range(1, 255));
    mem_b[12'h228] = 8'h00;
    mem_b[12'h229] = 8'h5A;

    // Reset together with start: reset wins.
    rst = 1'b1; start = 1'b1; base_addr = '0; max_len = 11'd4; nul_stop = 1'b0; ack_mode = 1'b0;
    exp_sent = 0; cur_ack = 1'b0;
    repeat (3) tick();
    start = 1'b0;
    check(busy == 1'b0, "reset_busy", busy, 0);
    check({mem_rd_en, out_strobe, done} == 3'b000, "reset_ctrl", {mem_rd_en, out_strobe, done}, 0);
    check(sent_count == 11'd0, "reset_sent_count", sent_count, 0);
    check(out_data == 8'h00, "reset_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // HELLO with NUL stop, then length limit across a word boundary.
    do_transfer(32'h0000_0100, 64, 1'b1, 1'b0, 1'b0);
    do_transfer(32'h0000_0102, 3, 1'b0, 1'b0, 1'b0);
    // Zero length, and a start pulse while busy.
    do_transfer(32'h0000_0300, 0, 1'b0, 1'b0, 1'b0);
    do_transfer(32'h0000_0200, 20, 1'b0, 1'b0, 1'b1);
    // Address wrap past the top of the address space.
    do_transfer(32'hFFFF_FFFE, 6, 1'b0, 1'b0, 1'b0);

    // Backpressure: slow acks on a 40-byte string.
    ack_delay  = 20;
    drop_delay = 2;
    max_level  = 0;
    do_transfer(32'h0000_0200, 64, 1'b1, 1'b1, 1'b0);
    check(max_level <= int'(DEPTH), "fifo_no_overflow", max_level, DEPTH);
    check(max_level == int'(DEPTH), "fifo_fills", max_level, DEPTH);

    // Reset after the second strobe.
    begin
      int n;
      int d0;
      load_expect(32'h0000_0200, 40, 1'b0, 1'b0);
      pulse_start(32'h0000_0200, 40, 1'b0, 1'b0);
      n = 0;
      while (tr_strobes < 2 && n < 2000) begin
        tick();
        n++;
      end
      check(tr_strobes >= 2, "two_strobes_before_rst", tr_strobes, 2);
      d0  = done_cnt;
      rst = 1'b1;
      tick();
      exp_q.delete();
      check({mem_rd_en, out_strobe, busy, done} == 4'b0000, "rst_mid_ctrl",
            {mem_rd_en, out_strobe, busy, done}, 0);
      check(out_data == 8'h00, "rst_mid_out_data", out_data, 0);
      check(sent_count == 11'd0, "rst_mid_sent_count", sent_count, 0);
      rst = 1'b0;
      repeat (10) tick();
      check(done_cnt == d0, "rst_no_done", done_cnt - d0, 0);
    end
    do_transfer(32'h0000_0100, 64, 1'b1, 1'b0, 1'b0);

    // Random transfers.
    for (int t = 0; t < 10; t++) begin
      a          = $urandom;
      ack_delay  = $urandom_range(0, 4);
      drop_delay = $urandom_range(0, 3);
      do_transfer(a, $urandom_range(0, 30), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_byte_streamer.md
MEM_BYTE_STREAMER -- requirements
Module: mem_byte_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory read-data width; multiple of 8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries; power of two, at least 4.
REQ-004 SHALL have parameter LEN_W, default 11, width of the length and count fields.
REQ-005 SHALL have parameter HALF_PERIOD, default 4, clk cycles per strobe phase; at least 1.
REQ-006 SHALL have port clk, input, 1, the only clock; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle pulse that begins a transfer; honoured only while idle.
REQ-009 SHALL have port base_addr, input, ADDR_W, first byte address; sampled on start.
REQ-010 SHALL have port max_len, input, LEN_W, byte limit; sampled on start.
REQ-011 SHALL have port nul_stop, input, 1, stop at a 0x00 byte when set; sampled on start.
REQ-012 SHALL have port ack_mode, input, 1, wait for out_ack on each byte when set; sampled on start.
REQ-013 SHALL have port mem_rd_en, output, 1, memory read request.
REQ-014 SHALL have port mem_addr, output, ADDR_W, read address, word-aligned (low bits zero).
REQ-015 SHALL have port mem_rdata, input, DATA_W, read data, valid exactly 1 cycle after mem_rd_en.
REQ-016 SHALL have port out_data, output, 8, byte on the parallel port.
REQ-017 SHALL have port out_strobe, output, 1, data-valid strobe.
REQ-018 SHALL have port out_ack, input, 1, external acknowledge; used only in ack_mode.
REQ-019 SHALL have port busy, output, 1, high from the start-accept cycle until done.
REQ-020 SHALL have port done, output, 1, single-cycle pulse at the end of a transfer.
REQ-021 SHALL have port sent_count, output, LEN_W, bytes emitted; held after done until the next start.

Function
REQ-022 SHALL run the states IDLE->RUN on start, RUN->FLUSH when fetching stops, FLUSH->IDLE when the FIFO is empty and the last strobe phase has completed.
REQ-023 SHALL fetch in RUN one byte per read: the byte address advances by 1 per issued read, and the byte lane is selected by the low address bits, little-endian.
REQ-024 SHALL issue a read only when FIFO occupancy plus reads in flight is below FIFO_DEPTH, so the FIFO never overflows.
REQ-025 SHALL stop fetching once max_len bytes are fetched, or, with nul_stop set, when a 0x00 byte returns; a NUL byte is never pushed to the FIFO or emitted.
REQ-026 SHALL discard any read already in flight after a NUL stop.
REQ-027 SHALL, with max_len=0, emit no bytes and pulse done 2 cycles after start.
REQ-028 SHALL, in strobe mode, emit each FIFO byte as out_data stable for the whole period, out_strobe high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles.
REQ-029 SHALL, in ack_mode, raise out_strobe and hold it until out_ack is sampled high, then drop it and wait for out_ack to go low before presenting the next byte.
REQ-030 SHALL increment sent_count on each strobe falling edge; sent_count saturates at max_len.
REQ-031 SHALL ignore start while busy.
REQ-032 SHALL wrap the byte address modulo 2^ADDR_W.

Reset
REQ-033 SHALL, on rst, go to IDLE and clear the FIFO, in-flight tracking, mem_rd_en, out_strobe, out_data, busy, done and sent_count to 0, including mid-transfer; no done pulse is generated.
REQ-034 SHALL give rst priority over start in the same cycle.

Structure
REQ-035 SHALL place the state encoding and default parameter constants in a shared package or defs header.
REQ-036 SHALL implement the byte FIFO as a separate sub-module byte_fifo (parameter DEPTH; push/pop, full/empty, level outputs).

Verification
REQ-037 SHALL cover NUL stop: memory holds "HELLO",0 at 0x100; start with base=0x100, max_len=64, nul_stop=1 -> 5 strobes with 0x48,0x45,0x4C,0x4C,0x4F, sent_count=5, one done pulse.
REQ-038 SHALL cover the length limit: nul_stop=0, max_len=3, base=0x102 -> bytes taken from lanes 2, 3, then lane 0 of the next word; sent_count=3.
REQ-039 SHALL cover backpressure: ack_mode=1 and out_ack delayed 20 cycles per byte with a 40-byte string -> no byte is lost or duplicated and FIFO level never exceeds FIFO_DEPTH.
REQ-040 SHALL cover reset mid-transfer: rst asserted after the 2nd strobe -> all outputs are 0 the next cycle, no done; a fresh start then transfers correctly.
REQ-041 SHALL cover edge cases: max_len=0 -> done 2 cycles after start with no strobe; start pulsed while busy -> ignored.
